ex_mem_reg: RTL and testbench
=============================

EX_MEM_REG -- requirements
Module: ex_mem_reg

Interface
REQ-001 SHALL have parameter MEMWRITE_BIT, default 21, which is the Controls bit index of MemWrite.
REQ-002 SHALL have parameter MEMREAD_BIT, default 20, which is the Controls bit index of MemRead.
REQ-003 SHALL have parameter REGWRITE_BIT, default 22, which is the Controls bit index of RegWrite.
REQ-004 Clk  in  1  single system clock, rising-edge.
REQ-005 Rst_n  in  1  reset, asynchronous, active-low.
REQ-006 Stall  in  1  hold the current contents.
REQ-007 Flush  in  1  insert a bubble.
REQ-008 CntClr  in  1  synchronous clear of the event counters.
REQ-009 In_Valid  in  1  the EX stage presents a real instruction.
REQ-010 In_ALUOut / In_WriteData / In_Controls  in  32 each  EX results and control word.
REQ-011 In_DestReg  in  5  destination register number.
REQ-012 ID_Rs / ID_Rt  in  5 each  source registers of the instruction in ID/EX.
REQ-013 ALUOut / MemoryWriteData / Controls  out  32 each  registered outputs that feed the MEM stage directly.
REQ-014 DestReg  out  5  registered destination.
REQ-015 Out_Valid  out  1  the register holds a real instruction.
REQ-016 LoadUse  out  1  load-use hazard request to the stall logic.
REQ-017 StallCount / FlushCount  out  16 each  event counters.
REQ-018 FwdA / FwdB  out  1 each  forward ALUOut to the EX A/B operand; present only with the macro (see Configuration).

Function
REQ-019 SHALL update state only on the Clk rising edge, apart from the asynchronous reset.
REQ-020 Priority SHALL be Flush > Stall > load.
REQ-021 On Flush: Out_Valid<=0 and Controls<=0; ALUOut, MemoryWriteData and DestReg hold their values.
REQ-022 On Stall without Flush: every pipeline output holds.
REQ-023 Otherwise, all outputs SHALL load their In_* values, giving 1-cycle latency; when In_Valid=0, Controls<=0 and Out_Valid<=0 (bubble), while the data fields still load.
REQ-024 Whenever Out_Valid=0, Controls SHALL equal 0, so no bubble can assert MemWrite to memory.
REQ-025 LoadUse (combinational) SHALL equal Out_Valid & Controls[MEMREAD_BIT] & (DestReg!=0) & (DestReg==ID_Rs | DestReg==ID_Rt).
REQ-026 StallCount SHALL increment on each edge with Stall=1 & Flush=0, and saturate at 16'hFFFF.
REQ-027 FlushCount SHALL increment on each edge with Flush=1, and saturate at 16'hFFFF.
REQ-028 CntClr=1 SHALL zero both counters on the next edge, with priority over increment; it SHALL NOT affect the pipeline fields.
REQ-029 Simultaneous Stall and Flush SHALL be treated as Flush, and counted only in FlushCount.

Reset
REQ-030 While Rst_n=0, all outputs SHALL be 0 immediately, independent of Clk: ALUOut, MemoryWriteData, Controls, DestReg, Out_Valid, both counters, and FwdA/FwdB where present.
REQ-031 Reset asserted mid-stall SHALL discard the held instruction.
REQ-032 The first edge after deassertion SHALL follow normal priority.

Configuration
REQ-033 The macro EXMEM_FWD_EN SHALL control forwarding.
REQ-034 With EXMEM_FWD_EN defined: FwdA = Out_Valid & Controls[REGWRITE_BIT] & ~Controls[MEMREAD_BIT] & (DestReg!=0) & (DestReg==ID_Rs); FwdB is the same with ID_Rt.
REQ-035 Without EXMEM_FWD_EN: the FwdA/FwdB ports and their logic SHALL be absent; everything else is unchanged.

Verification
REQ-036 Load: In_Valid=1, In_ALUOut=32'h10, In_Controls bit21=1, DestReg=5 -> one edge later ALUOut=32'h10, Controls[21]=1, Out_Valid=1.
REQ-037 Stall and Flush together: Stall=1, Flush=1 on one edge -> Controls=0, Out_Valid=0, FlushCount=1, StallCount=0; then Stall only for 3 edges -> outputs hold, StallCount=3.
REQ-038 Load-use: Controls[20]=1 and DestReg=7 held, ID_Rt=7 -> LoadUse=1; DestReg=0 -> LoadUse=0.
REQ-039 Counter saturation: 65540 Stall edges -> StallCount=16'hFFFF; then CntClr=1 together with Stall=1 -> 0.
REQ-040 Reset mid-operation: Rst_n low between edges with valid data held -> all outputs 0 immediately, before the next edge.
REQ-041 Forwarding (macro defined): RegWrite=1, DestReg=3, ID_Rs=3 -> FwdA=1, FwdB=0; the same case with MemRead=1 -> FwdA=0.

Source files
------------

// File: rtl/ex_mem_reg.sv
// ex_mem_reg : EX/MEM pipeline register with bubble insertion, load-use
// hazard detection and stall/flush event counters.
//
// Parameters:
//   MEMWRITE_BIT  Controls bit index of MemWrite (default 21)
//   MEMREAD_BIT   Controls bit index of MemRead  (default 20)
//   REGWRITE_BIT  Controls bit index of RegWrite (default 22)
//
// Ports:
//   Clk, Rst_n        rising-edge clock, async active-low reset
//   Stall, Flush      hold contents / insert bubble (Flush wins)
//   CntClr            synchronous clear of StallCount/FlushCount
//   In_Valid, In_*    EX stage instruction, results and control word
//   ID_Rs, ID_Rt      source registers of the instruction in ID/EX
//   ALUOut, MemoryWriteData, Controls, DestReg, Out_Valid
//                     registered MEM stage inputs
//   LoadUse           combinational load-use hazard request
//   StallCount, FlushCount  saturating 16-bit event counters
//   FwdA, FwdB        ALUOut forwarding selects (only with EXMEM_FWD_EN)
//
// Build option: define EXMEM_FWD_EN to add the FwdA/FwdB forwarding outputs.

module ex_mem_reg #(
  parameter int MEMWRITE_BIT = 21,
  parameter int MEMREAD_BIT  = 20,
  parameter int REGWRITE_BIT = 22
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        CntClr,
  input  logic        In_Valid,
  input  logic [31:0] In_ALUOut,
  input  logic [31:0] In_WriteData,
  input  logic [31:0] In_Controls,
  input  logic [4:0]  In_DestReg,
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  output logic [31:0] ALUOut,
  output logic [31:0] MemoryWriteData,
  output logic [31:0] Controls,
  output logic [4:0]  DestReg,
  output logic        Out_Valid,
  output logic        LoadUse,
  output logic [15:0] StallCount,
  output logic [15:0] FlushCount
`ifdef EXMEM_FWD_EN
  ,
  output logic        FwdA,
  output logic        FwdB
`endif
);

  logic dest_nz;
  logic match_rs;
  logic match_rt;

  // Pipeline fields. A bubble (Flush, or a non-valid EX slot) always carries
  // an all-zero control word so MemWrite can never leak to memory.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ALUOut          <= '0;
      MemoryWriteData <= '0;
      Controls        <= '0;
      DestReg         <= '0;
      Out_Valid       <= 1'b0;
    end else if (Flush) begin
      Controls  <= '0;
      Out_Valid <= 1'b0;
    end else if (!Stall) begin
      ALUOut          <= In_ALUOut;
      MemoryWriteData <= In_WriteData;
      DestReg         <= In_DestReg;
      Out_Valid       <= In_Valid;
      Controls        <= In_Valid ? In_Controls : '0;
    end
  end

  // Event counters; a Stall coinciding with Flush is counted as a flush only.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else if (CntClr) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else if (Flush) begin
      if (FlushCount != 16'hFFFF) FlushCount <= FlushCount + 16'd1;
    end else if (Stall) begin
      if (StallCount != 16'hFFFF) StallCount <= StallCount + 16'd1;
    end
  end

  assign dest_nz  = (DestReg != 5'd0);
  assign match_rs = (DestReg == ID_Rs);
  assign match_rt = (DestReg == ID_Rt);

  assign LoadUse = Out_Valid & Controls[MEMREAD_BIT] & dest_nz & (match_rs | match_rt);

`ifdef EXMEM_FWD_EN
  // A load's ALUOut is an address, not the result, so loads never forward.
  logic fwd_ok;
  assign fwd_ok = Out_Valid & Controls[REGWRITE_BIT] & ~Controls[MEMREAD_BIT] & dest_nz;
  assign FwdA   = fwd_ok & match_rs;
  assign FwdB   = fwd_ok & match_rt;
`endif

  // Simulation-only invariant: a bubble never presents MemWrite.
  always @(posedge Clk) begin
    if (Rst_n && !Out_Valid) assert (!Controls[MEMWRITE_BIT]);
  end

endmodule

// File: tb/tb_ex_mem_reg.sv
module tb_ex_mem_reg;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        Stall, Flush, CntClr, In_Valid;
  logic [31:0] In_ALUOut, In_WriteData, In_Controls;
  logic [4:0]  In_DestReg, ID_Rs, ID_Rt;
  logic [31:0] ALUOut, MemoryWriteData, Controls;
  logic [4:0]  DestReg;
  logic        Out_Valid, LoadUse;
  logic [15:0] StallCount, FlushCount;
`ifdef EXMEM_FWD_EN
  logic        FwdA, FwdB;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic chk_en = 1'b0;

  // Reference model state: what the register must hold, per the stage rules.
  logic [31:0] m_alu = '0, m_wd = '0, m_ctrl = '0;
  logic [4:0]  m_dest = '0;
  logic        m_valid = 1'b0;
  int          m_sc = 0, m_fc = 0;

  ex_mem_reg dut (
    .Clk(Clk), .Rst_n(Rst_n), .Stall(Stall), .Flush(Flush), .CntClr(CntClr),
    .In_Valid(In_Valid), .In_ALUOut(In_ALUOut), .In_WriteData(In_WriteData),
    .In_Controls(In_Controls), .In_DestReg(In_DestReg), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
    .ALUOut(ALUOut), .MemoryWriteData(MemoryWriteData), .Controls(Controls),
    .DestReg(DestReg), .Out_Valid(Out_Valid), .LoadUse(LoadUse),
    .StallCount(StallCount), .FlushCount(FlushCount)
`ifdef EXMEM_FWD_EN
    , .FwdA(FwdA), .FwdB(FwdB)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      m_alu <= '0; m_wd <= '0; m_ctrl <= '0; m_dest <= '0; m_valid <= 1'b0;
      m_sc <= 0; m_fc <= 0;
    end else begin
      if (CntClr) begin
        m_sc <= 0; m_fc <= 0;
      end else if (Flush) begin
        m_fc <= (m_fc < 65535) ? m_fc + 1 : 65535;
      end else if (Stall) begin
        m_sc <= (m_sc < 65535) ? m_sc + 1 : 65535;
      end
      if (Flush) begin
        m_valid <= 1'b0; m_ctrl <= '0;
      end else if (!Stall) begin
        m_alu <= In_ALUOut; m_wd <= In_WriteData; m_dest <= In_DestReg;
        m_valid <= In_Valid;
        m_ctrl <= In_Valid ? In_Controls : 32'h0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge Clk) begin
    if (chk_en) begin
      logic hit;
      hit = (m_dest != 0) && ((m_dest == ID_Rs) || (m_dest == ID_Rt));
      check("alu", ALUOut, m_alu);
      check("wdata", MemoryWriteData, m_wd);
      check("ctrl", Controls, m_ctrl);
      check("dest", {27'd0, DestReg}, {27'd0, m_dest});
      check("valid", {31'd0, Out_Valid}, {31'd0, m_valid});
      check("stallcnt", {16'd0, StallCount}, m_sc);
      check("flushcnt", {16'd0, FlushCount}, m_fc);
      check("loaduse", {31'd0, LoadUse}, {31'd0, m_valid && m_ctrl[20] && hit});
`ifdef EXMEM_FWD_EN
      check("fwda", {31'd0, FwdA},
            {31'd0, m_valid && m_ctrl[22] && !m_ctrl[20] && m_dest != 0 && m_dest == ID_Rs});
      check("fwdb", {31'd0, FwdB},
            {31'd0, m_valid && m_ctrl[22] && !m_ctrl[20] && m_dest != 0 && m_dest == ID_Rt});
`endif
    end
  end

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_alu"}, ALUOut, 32'h0);
    check({tag, "_wdata"}, MemoryWriteData, 32'h0);
    check({tag, "_ctrl"}, Controls, 32'h0);
    check({tag, "_dest"}, {27'd0, DestReg}, 32'h0);
    check({tag, "_valid"}, {31'd0, Out_Valid}, 32'h0);
    check({tag, "_stallcnt"}, {16'd0, StallCount}, 32'h0);
    check({tag, "_flushcnt"}, {16'd0, FlushCount}, 32'h0);
`ifdef EXMEM_FWD_EN
    check({tag, "_fwda"}, {31'd0, FwdA}, 32'h0);
    check({tag, "_fwdb"}, {31'd0, FwdB}, 32'h0);
`endif
  endtask

  initial begin
    Rst_n = 1'b1; Stall = 0; Flush = 0; CntClr = 0; In_Valid = 0;
    In_ALUOut = '0; In_WriteData = '0; In_Controls = '0; In_DestReg = '0;
    ID_Rs = '0; ID_Rt = '0;
    #1 Rst_n = 1'b0;
    #1 check_all_zero("reset");
    #8 Rst_n = 1'b1;
    chk_en = 1'b1;

    // Plain load
    In_Valid = 1; In_ALUOut = 32'h10; In_WriteData = 32'hDEADBEEF;
    In_Controls = 32'h0060_0000; In_DestReg = 5'd5;
    cyc();
    check("load_alu", ALUOut, 32'h10);
    check("load_mw", {31'd0, Controls[21]}, 32'h1);
    check("load_valid", {31'd0, Out_Valid}, 32'h1);
    check("load_dest", {27'd0, DestReg}, 32'd5);

    // Bubble from EX: data loads, controls zeroed
    In_Valid = 0; In_ALUOut = 32'h20; In_Controls = 32'hFFFF_FFFF; In_DestReg = 5'd9;
    cyc();
    check("bubble_ctrl", Controls, 32'h0);
    check("bubble_valid", {31'd0, Out_Valid}, 32'h0);
    check("bubble_alu", ALUOut, 32'h20);

    In_Valid = 1; In_ALUOut = 32'h30; In_Controls = 32'h00A0_0001; In_DestReg = 5'd6;
    cyc();

    // Stall+Flush together counts as a flush only
    Stall = 1; Flush = 1; In_ALUOut = 32'h40;
    cyc();
    check("sf_ctrl", Controls, 32'h0);
    check("sf_valid", {31'd0, Out_Valid}, 32'h0);
    check("sf_flushcnt", {16'd0, FlushCount}, 32'd1);
    check("sf_stallcnt", {16'd0, StallCount}, 32'd0);
    check("sf_alu_hold", ALUOut, 32'h30);
    Flush = 0;
    repeat (3) cyc();
    check("stall3_cnt", {16'd0, StallCount}, 32'd3);
    check("stall3_alu", ALUOut, 32'h30);

    // Load-use
    Stall = 0; In_Valid = 1; In_Controls = 32'h0050_0000; In_DestReg = 5'd7;
    In_ALUOut = 32'h50; ID_Rs = 5'd1; ID_Rt = 5'd7;
    cyc();
    check("lu_rt", {31'd0, LoadUse}, 32'h1);
    Stall = 1; ID_Rt = 5'd2; ID_Rs = 5'd7;
    #1 check("lu_rs", {31'd0, LoadUse}, 32'h1);
    ID_Rs = 5'd8;
    #1 check("lu_none", {31'd0, LoadUse}, 32'h0);
    Stall = 0; In_DestReg = 5'd0; ID_Rs = 5'd0; ID_Rt = 5'd0;
    cyc();
    check("lu_r0", {31'd0, LoadUse}, 32'h0);

`ifdef EXMEM_FWD_EN
    In_Controls = 32'h0040_0000; In_DestReg = 5'd3; ID_Rs = 5'd3; ID_Rt = 5'd4;
    cyc();
    check("fwd_a", {31'd0, FwdA}, 32'h1);
    check("fwd_b", {31'd0, FwdB}, 32'h0);
    In_Controls = 32'h0050_0000;
    cyc();
    check("fwd_load", {31'd0, FwdA}, 32'h0);
`endif

    // Mixed directed pattern, covered by the per-cycle model compare
    for (int i = 0; i < 24; i++) begin
      Stall = (i % 3 == 1); Flush = (i % 5 == 2); CntClr = (i == 7);
      In_Valid = (i % 4 != 3); In_ALUOut = 32'h100 + i;
      In_WriteData = 32'hA000 + i; In_Controls = 32'h0070_0000 ^ i;
      In_DestReg = 5'(i); ID_Rs = 5'(i + 1); ID_Rt = 5'(i);
      cyc();
    end
    Stall = 0; Flush = 0;

    // Saturation
    CntClr = 1; cyc(); CntClr = 0;
    Stall = 1;
    repeat (65540) cyc();
    check("sat_stallcnt", {16'd0, StallCount}, 32'h0000_FFFF);
    CntClr = 1;
    cyc();
    check("clr_stallcnt", {16'd0, StallCount}, 32'h0);
    CntClr = 0; Stall = 0;

    // Reset asserted mid-stall
    In_Valid = 1; In_ALUOut = 32'hCAFE; In_WriteData = 32'h1234;
    In_Controls = 32'h0020_0000; In_DestReg = 5'd12;
    cyc();
    Stall = 1;
    cyc();
    #1 Rst_n = 1'b0;
    #1 check_all_zero("midrst");
    #1 Rst_n = 1'b1;
    cyc();
    check("post_rst_valid", {31'd0, Out_Valid}, 32'h0);
    check("post_rst_alu", ALUOut, 32'h0);
    check("post_rst_stallcnt", {16'd0, StallCount}, 32'd1);
    Stall = 0; In_ALUOut = 32'h55;
    cyc();
    check("post_rst_load", ALUOut, 32'h55);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
